// File: rtl/spi_ram_ctrl.sv
// Command-driven RAM behind an SPI slave: each rx_valid rising edge applies one
// opcode (WADDR/WDATA/RADDR/RDATA), with arming flags guarding data transfers.
module spi_ram_ctrl #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] din,
  input  logic       rx_valid,
  output logic [7:0] dout,
  output logic       tx_valid,
  output logic       err
);

  localparam logic [1:0] NONE     = 2'b00;
  localparam logic [1:0] W_ARMED  = 2'b01;
  localparam logic [1:0] R_ARMED  = 2'b10;
  localparam logic [1:0] WR_ARMED = 2'b11;

  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_WDATA = 2'b01;
  localparam logic [1:0] OP_RADDR = 2'b10;
  localparam logic [1:0] OP_RDATA = 2'b11;

  logic [7:0]           mem [MEM_DEPTH];

  logic                 rx_valid_q;
  logic [1:0]           state_q, state_d;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]           dout_q, dout_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 err_q, err_d;
  logic                 mem_we;
  logic                 accept;
  logic                 w_armed, r_armed;

  function automatic logic [ADDR_SIZE-1:0] next_addr(input logic [ADDR_SIZE-1:0] a);
    return (a == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : a + ADDR_SIZE'(1);
  endfunction

  assign accept  = rx_valid && !rx_valid_q;
  assign w_armed = (state_q == W_ARMED) || (state_q == WR_ARMED);
  assign r_armed = (state_q == R_ARMED) || (state_q == WR_ARMED);

  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    if (accept) begin
      // Any accepted command drops tx_valid unless it is a successful read.
      tx_valid_d = 1'b0;
      unique case (din[9:8])
        OP_WADDR: begin
          wr_addr_d = din[ADDR_SIZE-1:0];
          state_d   = (state_q == NONE || state_q == W_ARMED) ? W_ARMED : WR_ARMED;
        end
        OP_WDATA: begin
          if (w_armed) begin
            mem_we    = 1'b1;
            wr_addr_d = next_addr(wr_addr_q);
          end else begin
            err_d = 1'b1;
          end
        end
        OP_RADDR: begin
          rd_addr_d = din[ADDR_SIZE-1:0];
          state_d   = (state_q == NONE || state_q == R_ARMED) ? R_ARMED : WR_ARMED;
        end
        OP_RDATA: begin
          if (r_armed) begin
            dout_d     = mem[rd_addr_q];
            tx_valid_d = 1'b1;
            rd_addr_d  = next_addr(rd_addr_q);
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      state_q    <= NONE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr_q] <= din[7:0];
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Self-checking bench for spi_ram_ctrl: command-level reference model compared
// every cycle, plus directed sequences with hand-computed literal expectations.
module tb_spi_ram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [9:0] din = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] dout;
  logic       tx_valid;
  logic       err;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] cap_dout;
  logic       cap_tx, cap_err;

  spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (din),
    .rx_valid (rx_valid),
    .dout     (dout),
    .tx_valid (tx_valid),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Reference model: one command per rx_valid rising edge, flags instead of states.
  logic [7:0] m_mem [256];
  bit         m_known [256];
  int         m_wa, m_ra;
  bit         m_w, m_r, m_prev, m_tx, m_err, m_dk;
  logic [7:0] m_dout;

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
    m_wa = 0; m_ra = 0; m_w = 0; m_r = 0; m_prev = 0;
    m_tx = 0; m_err = 0; m_dk = 1; m_dout = 8'h00;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wa = 0; m_ra = 0; m_w = 0; m_r = 0; m_prev = 0;
      m_tx = 0; m_err = 0; m_dk = 1; m_dout = 8'h00;
    end else begin
      m_err = 0;
      if (rx_valid && !m_prev) begin
        case (din[9:8])
          2'd0: begin m_wa = int'(din[7:0]); m_w = 1; m_tx = 0; end
          2'd1: begin
            m_tx = 0;
            if (m_w) begin
              m_mem[m_wa] = din[7:0];
              m_known[m_wa] = 1'b1;
              m_wa = (m_wa + 1) % 256;
            end else m_err = 1;
          end
          2'd2: begin m_ra = int'(din[7:0]); m_r = 1; m_tx = 0; end
          default: begin
            if (m_r) begin
              m_dout = m_mem[m_ra];
              m_dk = m_known[m_ra];
              m_tx = 1;
              m_ra = (m_ra + 1) % 256;
            end else begin
              m_tx = 0;
              m_err = 1;
            end
          end
        endcase
      end
      m_prev = rx_valid;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  bit cmp_on = 1'b1;
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_tx_valid", {7'b0, tx_valid}, {7'b0, m_tx});
      chk("model_err", {7'b0, err}, {7'b0, m_err});
      if (m_dk) chk("model_dout", dout, m_dout);
    end
  end

  // Called at posedge+1; holds rx_valid for 'hold' edges, captures outputs after
  // the last held edge, then leaves rx_valid low across one edge.
  task automatic cmd(input logic [9:0] w, input int hold);
    din = w;
    rx_valid = 1'b1;
    repeat (hold) @(posedge clk);
    #1;
    cap_dout = dout; cap_tx = tx_valid; cap_err = err;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    din = 10'h300;
    rx_valid = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_dout", dout, 8'h00);
    chk("reset_tx", {7'b0, tx_valid}, 8'h00);
    // rx_valid already high in the first cycle after reset: counts as an edge.
    @(posedge clk);
    #1;
    chk("unarmed_rd_err", {7'b0, err}, 8'h01);
    chk("unarmed_rd_tx", {7'b0, tx_valid}, 8'h00);
    chk("unarmed_rd_dout", dout, 8'h00);
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("unarmed_rd_err_gone", {7'b0, err}, 8'h00);

    // Basic write/read
    cmd(10'h005, 1);
    cmd(10'h1A5, 1);
    cmd(10'h205, 1);
    cmd(10'h300, 1);
    chk("basic_dout", cap_dout, 8'hA5);
    chk("basic_tx", {7'b0, cap_tx}, 8'h01);

    // tx_valid release on a non-read command
    cmd(10'h000, 1);
    chk("release_tx", {7'b0, cap_tx}, 8'h00);
    chk("release_dout", cap_dout, 8'hA5);

    // Address wrap-around
    cmd(10'h0FF, 1);
    cmd(10'h111, 1);
    cmd(10'h122, 1);
    cmd(10'h2FF, 1);
    cmd(10'h300, 1);
    chk("wrap_rd0", cap_dout, 8'h11);
    cmd(10'h300, 1);
    chk("wrap_rd1", cap_dout, 8'h22);
    chk("wrap_rd1_tx", {7'b0, cap_tx}, 8'h01);

    // Held rx_valid level: only one write
    cmd(10'h011, 1);
    cmd(10'h15A, 1);
    cmd(10'h15B, 1);
    cmd(10'h010, 1);
    cmd(10'h1AB, 5);
    cmd(10'h1CD, 1);
    cmd(10'h210, 1);
    cmd(10'h300, 1);
    chk("held_mem10", cap_dout, 8'hAB);
    cmd(10'h300, 1);
    chk("held_mem11", cap_dout, 8'hCD);
    cmd(10'h300, 1);
    chk("held_mem12", cap_dout, 8'h5B);

    // Reset in the middle of a read
    cmd(10'h205, 1);
    cmd(10'h300, 1);
    chk("pre_reset_dout", cap_dout, 8'hA5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dout", dout, 8'h00);
    chk("async_rst_tx", {7'b0, tx_valid}, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cmd(10'h177, 1);
    chk("unarmed_wr_err", {7'b0, cap_err}, 8'h01);
    cmd(10'h300, 1);
    chk("unarmed_rd2_err", {7'b0, cap_err}, 8'h01);
    chk("unarmed_rd2_tx", {7'b0, cap_tx}, 8'h00);
    cmd(10'h200, 1);
    cmd(10'h300, 1);
    chk("post_reset_mem00", cap_dout, 8'h22);
    cmd(10'h205, 1);
    cmd(10'h300, 1);
    chk("post_reset_mem05", cap_dout, 8'hA5);

    // Write to the address currently under read
    cmd(10'h006, 1);
    cmd(10'h1EE, 1);
    cmd(10'h300, 1);
    chk("rw_same_addr", cap_dout, 8'hEE);
    chk("rw_same_tx", {7'b0, cap_tx}, 8'h01);

    repeat (3) @(posedge clk);
    #1;
    cmp_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spi_ram_ctrl.md
SPI_RAM_CTRL -- requirements
Module: spi_ram_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_DEPTH, default 256, giving the number of 8-bit memory words.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 8, giving the address width; it SHALL equal clog2(MEM_DEPTH).
REQ-003 Port clk  input  1  system clock; all sequential logic SHALL be on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port din  input  10  command word from the SPI slave; [9:8] is the opcode and [7:0] is the payload.
REQ-006 Port rx_valid  input  1  command-valid level from the SPI slave; it may stay high for many cycles.
REQ-007 Port dout  output  8  read data returned to the SPI slave.
REQ-008 Port tx_valid  output  1  dout holds valid read data.
REQ-009 Port err  output  1  one-cycle pulse flagging a rejected command.

Function
REQ-010 The block SHALL register rx_valid into rx_valid_d, with rx_valid_d reset to 0.
REQ-011 The block SHALL accept a command only in a cycle where rx_valid=1 and rx_valid_d=0, i.e. once per rising edge of rx_valid.
REQ-012 A level held high SHALL NOT produce a repeated command.
REQ-013 rx_valid=1 in the first cycle after reset SHALL count as an edge.
REQ-014 Opcode 00 (WADDR) SHALL load wr_addr with din[ADDR_SIZE-1:0] and set the write-armed flag; higher payload bits SHALL be ignored.
REQ-015 Opcode 01 (WDATA) SHALL, if write-armed, write din[7:0] to mem[wr_addr] and then set wr_addr to wr_addr+1 modulo MEM_DEPTH, so MEM_DEPTH-1 wraps to 0.
REQ-016 Opcode 10 (RADDR) SHALL load rd_addr with din[ADDR_SIZE-1:0] and set the read-armed flag.
REQ-017 Opcode 11 (RDATA) SHALL, if read-armed, register mem[rd_addr] into dout, set tx_valid=1, and then set rd_addr to rd_addr+1 modulo MEM_DEPTH.
REQ-018 For RDATA, dout and tx_valid SHALL be valid on the clock edge after the accepting edge (1-cycle latency).
REQ-019 The arming flags SHALL form a 4-state FSM: NONE, W_ARMED, R_ARMED, WR_ARMED.
REQ-020 FSM transitions SHALL be: WADDR adds W; RADDR adds R; no other event clears an armed flag except reset.
REQ-021 WDATA in NONE or R_ARMED SHALL be rejected: no memory write, no address change, err=1 for exactly one cycle after the accepting edge.
REQ-022 RDATA in NONE or W_ARMED SHALL be rejected: dout unchanged, tx_valid=0, err=1 for one cycle.
REQ-023 tx_valid SHALL stay high and dout SHALL stay stable until the next accepted command.
REQ-024 On any accepted non-RDATA command, tx_valid SHALL fall in the same update cycle.
REQ-025 A back-to-back accepted RDATA SHALL keep tx_valid=1 and SHALL present the new dout.
REQ-026 Write and read addresses SHALL be independent; a write to the address under read SHALL be visible to the next RDATA.
REQ-027 The memory SHALL be single-port, with synchronous write and registered read.
REQ-028 At most one memory access SHALL occur per cycle.
REQ-029 err SHALL be 0 in every cycle except the cycle following a rejected command.

Reset
REQ-030 rst_n low SHALL immediately force dout=0x00, tx_valid=0, err=0, wr_addr=0, rd_addr=0, FSM=NONE and rx_valid_d=0, including when asserted mid-operation.
REQ-031 Memory contents SHALL NOT be cleared by reset; they are undefined until written.
REQ-032 After rst_n deasserts, the block SHALL accept commands on the first rising clock edge.

Verification
REQ-033 Basic write/read: din 0x005, 0x1A5, 0x205, 0x300, each with its own rx_valid pulse -> mem[0x05]=0xA5; dout=0xA5 and tx_valid=1 one cycle after the RDATA edge.
REQ-034 Wrap-around: WADDR 0xFF, WDATA 0x11, WDATA 0x22, RADDR 0xFF, RDATA, RDATA -> dout sequence 0x11 then 0x22; mem[0x00]=0x22.
REQ-035 Unarmed read: RDATA (0x3xx) right after reset -> err high for exactly 1 cycle, tx_valid=0, dout=0x00; unarmed WDATA likewise writes nothing.
REQ-036 Held level: rx_valid held high 5 cycles with din=0x1AB after WADDR 0x10 -> only mem[0x10]=0xAB is written and wr_addr=0x11.
REQ-037 tx_valid release: after a successful RDATA, WADDR 0x00 -> tx_valid=0 one cycle after that edge, with dout unchanged.
REQ-038 Reset mid-read: assert rst_n while tx_valid=1 -> dout=0x00 and tx_valid=0 asynchronously; after re-arming with RADDR, previously written data reads back intact.
